dm_port_arbiter: RTL and testbench

- Shares the single data-memory/IO port (DM plus switch/LED map) between the pipeline memory stage (CPU) and a program loader/debug requester.
- CPU has priority. A starvation counter guarantees the loader a slot.
- In boot mode the loader owns the port exclusively and the CPU is held stalled.
- Sits between memory_stage and dm_io. Drives the pipeline stall.

---
 rtl/dm_arb_pkg.sv | 19 +
 rtl/dm_starve_ctr.sv | 28 ++
 rtl/dm_port_arbiter.sv | 106 ++++++++++
 tb/tb_dm_port_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and DMCtrl codes for the data-memory port arbiter.
package dm_arb_pkg;

  localparam int DMCTRL_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RUN_ACK  = 2'd1,
    BOOT     = 2'd2,
    BOOT_ACK = 2'd3
  } dm_state_t;

  localparam logic [DMCTRL_W-1:0] DMC_WORD   = 3'b000;
  localparam logic [DMCTRL_W-1:0] DMC_HALF_S = 3'b001;
  localparam logic [DMCTRL_W-1:0] DMC_HALF_U = 3'b010;
  localparam logic [DMCTRL_W-1:0] DMC_BYTE_S = 3'b011;
  localparam logic [DMCTRL_W-1:0] DMC_BYTE_U = 3'b100;

endpackage

// File: rtl/dm_starve_ctr.sv
// Saturating count of CPU grants taken while the loader waits.
module dm_starve_ctr
  import dm_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  logic [3:0] cnt;

  assign limit_hit = (cnt == 4'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !limit_hit) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the DM/IO port between the memory stage and the loader.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                boot_mode,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [ADDR_W-1:0]   cpu_wdata,
  input  logic [DMCTRL_W-1:0] cpu_ctrl,
  output logic [ADDR_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  input  logic                ldr_req,
  input  logic                ldr_we,
  input  logic [ADDR_W-1:0]   ldr_addr,
  input  logic [ADDR_W-1:0]   ldr_wdata,
  input  logic [DMCTRL_W-1:0] ldr_ctrl,
  output logic                ldr_ack,
  output logic [ADDR_W-1:0]   ldr_rdata,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [ADDR_W-1:0]   mem_wdata,
  output logic [DMCTRL_W-1:0] mem_ctrl,
  input  logic [ADDR_W-1:0]   mem_rdata,
  output logic                grant_ldr
);

  dm_state_t state, state_nxt;
  logic      in_boot;
  logic      ldr_elig;
  logic      cpu_gnt;
  logic      limit_hit;

  dm_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (ldr_req & cpu_gnt),
    .clr      (grant_ldr | ~ldr_req),
    .limit_hit(limit_hit)
  );

  assign in_boot  = (state == BOOT) || (state == BOOT_ACK);
  assign ldr_elig = ldr_req && ((state == RUN) || (state == BOOT));

  always_comb begin
    grant_ldr = 1'b0;
    cpu_gnt   = 1'b0;
    cpu_stall = 1'b0;
    if (!rst) begin
      if (in_boot) begin
        grant_ldr = ldr_elig;
        cpu_stall = 1'b1;
      end else begin
        grant_ldr = ldr_elig && (!cpu_req || limit_hit);
        cpu_gnt   = cpu_req && !grant_ldr;
        cpu_stall = cpu_req && grant_ldr;
      end
    end
  end

  always_comb begin
    mem_addr  = grant_ldr ? ldr_addr  : cpu_addr;
    mem_wdata = grant_ldr ? ldr_wdata : cpu_wdata;
    mem_ctrl  = grant_ldr ? ldr_ctrl  : cpu_ctrl;
    mem_we    = grant_ldr ? ldr_we    : (cpu_gnt && cpu_we);
  end

  assign cpu_rdata = mem_rdata;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (grant_ldr)      state_nxt = RUN_ACK;
        else if (boot_mode) state_nxt = BOOT;
      end
      RUN_ACK:  state_nxt = boot_mode ? BOOT : RUN;
      BOOT: begin
        if (grant_ldr)       state_nxt = BOOT_ACK;
        else if (!boot_mode) state_nxt = RUN;
      end
      BOOT_ACK: state_nxt = boot_mode ? BOOT : RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      ldr_ack   <= 1'b0;
      ldr_rdata <= '0;
    end else begin
      state   <= state_nxt;
      ldr_ack <= grant_ldr;
      if (grant_ldr) ldr_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a word-addressed memory model.
module tb_dm_port_arbiter;
  import dm_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_mode;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_ctrl;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        ldr_req, ldr_we;
  logic [31:0] ldr_addr, ldr_wdata;
  logic [2:0]  ldr_ctrl;
  logic        ldr_ack;
  logic [31:0] ldr_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_ctrl;
  logic [31:0] mem_rdata;
  logic        grant_ldr;

  int checks   = 0;
  int failures = 0;

  logic [31:0] tb_mem [0:255] = '{default: '0};

  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr[9:2]];

  always @(posedge clk)
    if (mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;

  dm_port_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .boot_mode(boot_mode),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ctrl (cpu_ctrl),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .ldr_req  (ldr_req),
    .ldr_we   (ldr_we),
    .ldr_addr (ldr_addr),
    .ldr_wdata(ldr_wdata),
    .ldr_ctrl (ldr_ctrl),
    .ldr_ack  (ldr_ack),
    .ldr_rdata(ldr_rdata),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ctrl (mem_ctrl),
    .mem_rdata(mem_rdata),
    .grant_ldr(grant_ldr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; boot_mode = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40;
    cpu_wdata = 32'h1; cpu_ctrl = DMC_WORD;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h44;
    ldr_wdata = 32'h2; ldr_ctrl = DMC_WORD;
    mid();
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_grant", 32'(grant_ldr), 32'h0);
    chk("rst_stall", 32'(cpu_stall), 32'h0);
    tick();

    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; ldr_req = 1'b0;
    cpu_addr = 32'h3C;
    mid();
    chk("post_rst_ack", 32'(ldr_ack), 32'h0);
    chk("post_rst_rdata", ldr_rdata, 32'h0);
    chk("idle_mem_we", 32'(mem_we), 32'h0);
    chk("idle_stall", 32'(cpu_stall), 32'h0);
    chk("idle_grant", 32'(grant_ldr), 32'h0);
    chk("idle_addr", mem_addr, 32'h3C);
    tick();

    // CPU store then load
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10;
    cpu_wdata = 32'hDEADBEEF; cpu_ctrl = DMC_WORD;
    mid();
    chk("cpu_st_we", 32'(mem_we), 32'h1);
    chk("cpu_st_addr", mem_addr, 32'h10);
    chk("cpu_st_wdata", mem_wdata, 32'hDEADBEEF);
    chk("cpu_st_stall", 32'(cpu_stall), 32'h0);
    chk("cpu_st_grant", 32'(grant_ldr), 32'h0);
    tick();
    cpu_we = 1'b0; cpu_ctrl = DMC_BYTE_U;
    mid();
    chk("cpu_ld_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("cpu_ld_we", 32'(mem_we), 32'h0);
    chk("cpu_ld_ctrl", 32'(mem_ctrl), 32'(DMC_BYTE_U));
    tick();

    // Loader read, request held through the ack cycle
    cpu_req = 1'b0; cpu_addr = 32'h0;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h10;
    ldr_ctrl = DMC_HALF_S;
    mid();
    chk("ldr_rd_grant", 32'(grant_ldr), 32'h1);
    chk("ldr_rd_addr", mem_addr, 32'h10);
    chk("ldr_rd_ctrl", 32'(mem_ctrl), 32'(DMC_HALF_S));
    chk("ldr_rd_ack0", 32'(ldr_ack), 32'h0);
    tick();
    mid();
    chk("ldr_rd_ack1", 32'(ldr_ack), 32'h1);
    chk("ldr_rd_data", ldr_rdata, 32'hDEADBEEF);
    chk("ldr_rd_nodup", 32'(grant_ldr), 32'h0);
    tick();
    ldr_req = 1'b0;
    mid();
    chk("ldr_rd_ack2", 32'(ldr_ack), 32'h0);
    tick();

    // Starvation: CPU busy every cycle, loader write pending
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h20;
    ldr_wdata = 32'h12345678; ldr_ctrl = DMC_WORD;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk($sformatf("starve_cpu%0d_grant", i), 32'(grant_ldr), 32'h0);
      chk($sformatf("starve_cpu%0d_stall", i), 32'(cpu_stall), 32'h0);
      chk($sformatf("starve_cpu%0d_addr", i), mem_addr, 32'h10);
      tick();
    end
    mid();
    chk("starve_grant", 32'(grant_ldr), 32'h1);
    chk("starve_stall", 32'(cpu_stall), 32'h1);
    chk("starve_we", 32'(mem_we), 32'h1);
    chk("starve_addr", mem_addr, 32'h20);
    tick();
    mid();
    chk("starve_ack", 32'(ldr_ack), 32'h1);
    chk("starve_ack_grant", 32'(grant_ldr), 32'h0);
    chk("starve_ack_stall", 32'(cpu_stall), 32'h0);
    tick();
    ldr_req = 1'b0; cpu_addr = 32'h20;
    mid();
    chk("starve_wr_data", cpu_rdata, 32'h12345678);
    tick();

    // Counter restarted: a new loader request waits 4 CPU grants again
    cpu_addr = 32'h10; ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk($sformatf("restart%0d_grant", i), 32'(grant_ldr), 32'h0);
      tick();
    end
    mid();
    chk("restart_grant", 32'(grant_ldr), 32'h1);
    tick();
    ldr_req = 1'b0;
    mid();
    chk("restart_rdata", ldr_rdata, 32'h12345678);
    tick();

    // Boot mode: sampling cycle still uses RUN rules
    boot_mode = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    mid();
    chk("boot_enter_stall", 32'(cpu_stall), 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      ldr_req = 1'b1; ldr_we = 1'b1;
      ldr_addr = 32'h100 + 32'(4 * k);
      ldr_wdata = 32'hA0 + 32'(k);
      mid();
      chk($sformatf("boot%0d_grant", k), 32'(grant_ldr), 32'h1);
      chk($sformatf("boot%0d_stall", k), 32'(cpu_stall), 32'h1);
      chk($sformatf("boot%0d_addr", k), mem_addr, 32'h100 + 32'(4 * k));
      tick();
      mid();
      chk($sformatf("boot%0d_ack", k), 32'(ldr_ack), 32'h1);
      chk($sformatf("boot%0d_ackgrant", k), 32'(grant_ldr), 32'h0);
      chk($sformatf("boot%0d_ackstall", k), 32'(cpu_stall), 32'h1);
      chk($sformatf("boot%0d_ackwe", k), 32'(mem_we), 32'h0);
      tick();
    end
    ldr_req = 1'b0; boot_mode = 1'b0;
    mid();
    chk("boot_exit_stall", 32'(cpu_stall), 32'h1);
    tick();
    cpu_addr = 32'h108;
    mid();
    chk("run_again_stall", 32'(cpu_stall), 32'h0);
    chk("run_again_addr", mem_addr, 32'h108);
    chk("run_again_rdata", cpu_rdata, 32'hA2);
    tick();

    // Reset arriving while the loader is granted a write
    cpu_req = 1'b0; ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h10;
    mid();
    chk("pre_rst_grant", 32'(grant_ldr), 32'h1);
    tick();
    ldr_req = 1'b0;
    mid();
    chk("pre_rst_rdata", ldr_rdata, 32'hDEADBEEF);
    tick();
    rst = 1'b1; ldr_req = 1'b1; ldr_we = 1'b1;
    ldr_addr = 32'h30; ldr_wdata = 32'h55;
    mid();
    chk("midrst_we", 32'(mem_we), 32'h0);
    chk("midrst_grant", 32'(grant_ldr), 32'h0);
    tick();
    rst = 1'b0; ldr_we = 1'b0;
    mid();
    chk("midrst_ack", 32'(ldr_ack), 32'h0);
    chk("midrst_rdata", ldr_rdata, 32'h0);
    chk("midrst_run_grant", 32'(grant_ldr), 32'h1);
    chk("midrst_run_stall", 32'(cpu_stall), 32'h0);
    tick();
    ldr_req = 1'b0;
    mid();
    chk("midrst_nowrite", ldr_rdata, 32'h0);
    chk("midrst_ack2", 32'(ldr_ack), 32'h1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
